// File: rtl/cordic_pkg.sv
// Shared types and constants for the iterative CORDIC engine.
//   state_e   : sequencing FSM states (IDLE, RUN, DONE)
//   angle_pi  : angle code that represents pi for a given word width
//   CORDIC_K / CORDIC_INV_K : rotation gain and its reciprocal (reference only)
package cordic_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Angle code for pi: 2^(width-1), so the full angle range is [-pi, pi).
  function automatic logic [63:0] angle_pi(input int unsigned width);
    return 64'(1) << (width - 1);
  endfunction

  localparam int unsigned ANGLE_PI_16 = 32'd32768;

  // Gain accumulated by the micro-rotations; results are not compensated,
  // so producers pre-scale vectors by CORDIC_INV_K.
  localparam real CORDIC_K     = 1.646760258;
  localparam real CORDIC_INV_K = 0.607252935;

endpackage

// File: rtl/cordic_microrot.sv
// Single combinational CORDIC micro-rotation.
//   x, y, z   : current vector and residual angle (signed)
//   i         : iteration index, used as the arithmetic shift amount
//   lut_value : atan(2^-i) angle step
//   dir_neg   : 0 selects d=+1, 1 selects d=-1
//   x_nxt, y_nxt, z_nxt : rotated vector and updated angle (wrapping)
module cordic_microrot #(
  parameter int unsigned BIT_WIDTH   = 16,
  parameter int unsigned INPUT_WIDTH = 4
) (
  input  logic signed [BIT_WIDTH-1:0]   x,
  input  logic signed [BIT_WIDTH-1:0]   y,
  input  logic signed [BIT_WIDTH-1:0]   z,
  input  logic        [INPUT_WIDTH-1:0] i,
  input  logic signed [BIT_WIDTH-1:0]   lut_value,
  input  logic                          dir_neg,
  output logic signed [BIT_WIDTH-1:0]   x_nxt,
  output logic signed [BIT_WIDTH-1:0]   y_nxt,
  output logic signed [BIT_WIDTH-1:0]   z_nxt
);

  logic signed [BIT_WIDTH-1:0] y_sh;
  logic signed [BIT_WIDTH-1:0] x_sh;

  assign y_sh = y >>> i;
  assign x_sh = x >>> i;

  // Add/subtract with natural wrap at BIT_WIDTH.
  always_comb begin
    if (dir_neg) begin
      x_nxt = x + y_sh;
      y_nxt = y - x_sh;
      z_nxt = z + lut_value;
    end else begin
      x_nxt = x - y_sh;
      y_nxt = y + x_sh;
      z_nxt = z - lut_value;
    end
  end

endmodule

// File: rtl/cordic_iter.sv
// Iterative CORDIC engine: one micro-rotation per clock, ITERATIONS steps per
// accepted (x, y, z) triple. Owns the external arctangent step table index.
//   clk, rst_n            : clock, asynchronous active-low reset
//   in_valid / in_ready   : input triple handshake (x_in, y_in, z_in)
//   out_valid / out_ready : result handshake (x_out, y_out, z_out)
//   lut_index / lut_value : step table index out, atan(2^-index) back same cycle
//   mode_in               : 0 rotation, 1 vectoring; only with CORDIC_VECTORING_EN
module cordic_iter
  import cordic_pkg::*;
#(
  parameter int unsigned BIT_WIDTH   = 16,
  parameter int unsigned ITERATIONS  = 16,
  parameter int unsigned INPUT_WIDTH = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic signed [BIT_WIDTH-1:0]   x_in,
  input  logic signed [BIT_WIDTH-1:0]   y_in,
  input  logic signed [BIT_WIDTH-1:0]   z_in,
`ifdef CORDIC_VECTORING_EN
  input  logic                          mode_in,
`endif
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic signed [BIT_WIDTH-1:0]   x_out,
  output logic signed [BIT_WIDTH-1:0]   y_out,
  output logic signed [BIT_WIDTH-1:0]   z_out,
  output logic        [INPUT_WIDTH-1:0] lut_index,
  input  logic signed [BIT_WIDTH-1:0]   lut_value
);

  localparam logic [INPUT_WIDTH-1:0] LAST_IDX = INPUT_WIDTH'(ITERATIONS - 1);

  state_e                       state_q, state_d;
  logic [INPUT_WIDTH-1:0]       i_q, i_d;
  logic signed [BIT_WIDTH-1:0]  x_q, x_d, y_q, y_d, z_q, z_d;
  logic signed [BIT_WIDTH-1:0]  x_out_q, x_out_d, y_out_q, y_out_d, z_out_q, z_out_d;
  logic                         in_ready_q, in_ready_d;
  logic                         out_valid_q, out_valid_d;
  logic signed [BIT_WIDTH-1:0]  x_nxt, y_nxt, z_nxt;
  logic                         dir_neg;
`ifdef CORDIC_VECTORING_EN
  logic                         mode_q, mode_d;
`endif

  // Direction: rotation drives z to 0, vectoring drives y to 0.
`ifdef CORDIC_VECTORING_EN
  assign dir_neg = mode_q ? ~y_q[BIT_WIDTH-1] : z_q[BIT_WIDTH-1];
`else
  assign dir_neg = z_q[BIT_WIDTH-1];
`endif

  cordic_microrot #(
    .BIT_WIDTH   (BIT_WIDTH),
    .INPUT_WIDTH (INPUT_WIDTH)
  ) u_microrot (
    .x         (x_q),
    .y         (y_q),
    .z         (z_q),
    .i         (i_q),
    .lut_value (lut_value),
    .dir_neg   (dir_neg),
    .x_nxt     (x_nxt),
    .y_nxt     (y_nxt),
    .z_nxt     (z_nxt)
  );

  // Next-state and datapath control. i_q is held at 0 outside RUN, so it can
  // drive lut_index directly.
  always_comb begin
    state_d     = state_q;
    i_d         = i_q;
    x_d         = x_q;
    y_d         = y_q;
    z_d         = z_q;
    x_out_d     = x_out_q;
    y_out_d     = y_out_q;
    z_out_d     = z_out_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
`ifdef CORDIC_VECTORING_EN
    mode_d      = mode_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          x_d        = x_in;
          y_d        = y_in;
          z_d        = z_in;
`ifdef CORDIC_VECTORING_EN
          mode_d     = mode_in;
`endif
          i_d        = '0;
          state_d    = RUN;
          in_ready_d = 1'b0;
        end
      end
      RUN: begin
        x_d = x_nxt;
        y_d = y_nxt;
        z_d = z_nxt;
        if (i_q == LAST_IDX) begin
          x_out_d     = x_nxt;
          y_out_d     = y_nxt;
          z_out_d     = z_nxt;
          i_d         = '0;
          state_d     = DONE;
          out_valid_d = 1'b1;
        end else begin
          i_d = i_q + INPUT_WIDTH'(1);
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
        end
      end
      default: begin
        state_d     = IDLE;
        i_d         = '0;
        out_valid_d = 1'b0;
        in_ready_d  = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      i_q         <= '0;
      x_q         <= '0;
      y_q         <= '0;
      z_q         <= '0;
      x_out_q     <= '0;
      y_out_q     <= '0;
      z_out_q     <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
`ifdef CORDIC_VECTORING_EN
      mode_q      <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      i_q         <= i_d;
      x_q         <= x_d;
      y_q         <= y_d;
      z_q         <= z_d;
      x_out_q     <= x_out_d;
      y_out_q     <= y_out_d;
      z_out_q     <= z_out_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
`ifdef CORDIC_VECTORING_EN
      mode_q      <= mode_d;
`endif
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign x_out     = x_out_q;
  assign y_out     = y_out_q;
  assign z_out     = z_out_q;
  assign lut_index = i_q;

endmodule

// File: tb/tb_cordic_iter.sv
// Scoreboard bench for cordic_iter (16-bit, 16 iterations) with a behavioral
// arctangent step table. Define CORDIC_VECTORING_EN to also exercise vectoring.
module tb_cordic_iter;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               in_valid;
  logic               in_ready;
  logic signed [15:0] x_in, y_in, z_in;
`ifdef CORDIC_VECTORING_EN
  logic               mode_in;
`endif
  logic               out_valid;
  logic               out_ready;
  logic signed [15:0] x_out, y_out, z_out;
  logic        [3:0]  lut_index;
  logic signed [15:0] lut_value;

  typedef struct {
    int tag;
    int x; int y; int z;
    int tx; int ty; int tz;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  cordic_iter #(
    .BIT_WIDTH   (16),
    .ITERATIONS  (16),
    .INPUT_WIDTH (4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x_in      (x_in),
    .y_in      (y_in),
    .z_in      (z_in),
`ifdef CORDIC_VECTORING_EN
    .mode_in   (mode_in),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .x_out     (x_out),
    .y_out     (y_out),
    .z_out     (z_out),
    .lut_index (lut_index),
    .lut_value (lut_value)
  );

  // round(atan(2^-i) * 32768 / pi)
  always_comb begin
    case (lut_index)
      4'd0:  lut_value = 16'sd8192;
      4'd1:  lut_value = 16'sd4836;
      4'd2:  lut_value = 16'sd2555;
      4'd3:  lut_value = 16'sd1297;
      4'd4:  lut_value = 16'sd651;
      4'd5:  lut_value = 16'sd326;
      4'd6:  lut_value = 16'sd163;
      4'd7:  lut_value = 16'sd81;
      4'd8:  lut_value = 16'sd41;
      4'd9:  lut_value = 16'sd20;
      4'd10: lut_value = 16'sd10;
      4'd11: lut_value = 16'sd5;
      4'd12: lut_value = 16'sd3;
      4'd13: lut_value = 16'sd1;
      4'd14: lut_value = 16'sd1;
      default: lut_value = 16'sd0;
    endcase
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic chk_tol(input string name, input int tag, input int act,
                         input int exp, input int tol);
    int d;
    d = act - exp;
    if (d < 0) d = -d;
    checks++;
    if (d > tol) begin
      errors++;
      $display("FAIL res%0d_%s actual=%0d expected=%0d tol=%0d", tag, name, act, exp, tol);
    end
  endtask

  // Monitor: pops one expectation per result handshake.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_result actual=%0d expected=none", x_out);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk_tol("x", e.tag, int'(x_out), e.x, e.tx);
        chk_tol("y", e.tag, int'(y_out), e.y, e.ty);
        chk_tol("z", e.tag, int'(z_out), e.z, e.tz);
      end
    end
  end

  // Drive one triple; called just after a rising edge, returns just after
  // the accept edge.
  task automatic send(input int x, input int y, input int z, input bit mode,
                      input bit push, input exp_t e);
    int n;
    n = 0;
    while (!in_ready && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_ready) chk("send_timeout_in_ready", 0, 1);
    x_in = 16'(x);
    y_in = 16'(y);
    z_in = 16'(z);
`ifdef CORDIC_VECTORING_EN
    mode_in = mode;
`else
    if (mode) $display("note: vectoring request ignored in rotation-only build");
`endif
    in_valid = 1'b1;
    if (push) sb.push_back(e);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Wait for out_valid; optionally advance past the handshake edge.
  task automatic wait_done(input bit consume);
    int n;
    n = 0;
    while (!out_valid && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (!out_valid) chk("wait_done_timeout", 0, 1);
    if (consume) begin
      @(posedge clk); #1;
    end
  endtask

  function automatic exp_t mk(input int tag, input int x, input int y, input int z,
                              input int tx, input int ty, input int tz);
    exp_t e;
    e.tag = tag; e.x = x; e.y = y; e.z = z; e.tx = tx; e.ty = ty; e.tz = tz;
    return e;
  endfunction

  initial begin
    int sx, sy, sz;
    rst_n     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    x_in = '0; y_in = '0; z_in = '0;
`ifdef CORDIC_VECTORING_EN
    mode_in = 1'b0;
`endif
    #2 rst_n = 1'b0;
    #1;
    chk("rst_in_ready",  int'(in_ready), 1);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_lut_index", int'(lut_index), 0);
    chk("rst_x_out",     int'(x_out), 0);
    chk("rst_y_out",     int'(y_out), 0);
    chk("rst_z_out",     int'(z_out), 0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // 45 degrees with per-cycle index / latency checks.
    send(9949, 0, 8192, 1'b0, 1'b1, mk(1, 11585, 11585, 0, 4, 4, 2));
    for (int k = 0; k < 16; k++) begin
      chk($sformatf("idx_cycle%0d", k), int'(lut_index), k);
      chk($sformatf("run_out_valid%0d", k), int'(out_valid), 0);
      chk($sformatf("run_in_ready%0d", k), int'(in_ready), 0);
      @(posedge clk); #1;
    end
    chk("lat_out_valid", int'(out_valid), 1);
    chk("done_lut_index", int'(lut_index), 0);
    chk("done_in_ready", int'(in_ready), 0);
    @(posedge clk); #1;
    chk("post_hs_in_ready", int'(in_ready), 1);
    chk("post_hs_out_valid", int'(out_valid), 0);

    // Further rotation vectors.
    send(9949, 0, 0,      1'b0, 1'b1, mk(2, 16384, 0, 0, 4, 4, 2));
    wait_done(1'b1);
    send(9949, 0, -8192,  1'b0, 1'b1, mk(3, 11585, -11585, 0, 4, 4, 2));
    wait_done(1'b1);
    send(9949, 0, 5461,   1'b0, 1'b1, mk(4, 14189, 8192, 0, 6, 6, 2));
    wait_done(1'b1);
    send(0, 9949, 0,      1'b0, 1'b1, mk(5, 0, 16384, 0, 6, 6, 2));
    wait_done(1'b1);

    // Backpressure with in_valid toggling during DONE.
    out_ready = 1'b0;
    send(9949, 0, 5461, 1'b0, 1'b1, mk(6, 14189, 8192, 0, 6, 6, 2));
    wait_done(1'b0);
    sx = int'(x_out); sy = int'(y_out); sz = int'(z_out);
    for (int k = 0; k < 5; k++) begin
      in_valid = ~in_valid;
      x_in = 16'sd1234; y_in = -16'sd777; z_in = 16'sd3000;
      @(posedge clk); #1;
      chk($sformatf("bp_x_hold%0d", k), int'(x_out), sx);
      chk($sformatf("bp_y_hold%0d", k), int'(y_out), sy);
      chk($sformatf("bp_z_hold%0d", k), int'(z_out), sz);
      chk($sformatf("bp_out_valid%0d", k), int'(out_valid), 1);
      chk($sformatf("bp_in_ready%0d", k), int'(in_ready), 0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_resume_in_ready", int'(in_ready), 1);
    send(9949, 0, -8192, 1'b0, 1'b1, mk(7, 11585, -11585, 0, 4, 4, 2));
    chk("bp_accept_in_ready", int'(in_ready), 0);
    wait_done(1'b1);

    // Reset at RUN iteration 7; in-flight result is dropped.
    send(9949, 0, 8192, 1'b0, 1'b0, mk(0, 0, 0, 0, 0, 0, 0));
    repeat (7) begin
      @(posedge clk); #1;
    end
    chk("mid_run_index", int'(lut_index), 7);
    rst_n = 1'b0;
    #1;
    chk("mr_x_out", int'(x_out), 0);
    chk("mr_y_out", int'(y_out), 0);
    chk("mr_z_out", int'(z_out), 0);
    chk("mr_in_ready", int'(in_ready), 1);
    chk("mr_out_valid", int'(out_valid), 0);
    chk("mr_lut_index", int'(lut_index), 0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    send(9949, 0, 0, 1'b0, 1'b1, mk(8, 16384, 0, 0, 4, 4, 2));
    wait_done(1'b1);

`ifdef CORDIC_VECTORING_EN
    send(10000, 10000, 0, 1'b1, 1'b1, mk(9, 23289, 0, 8192, 8, 4, 2));
    wait_done(1'b1);
`endif

    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard_drained", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
